ring_token_arbiter: RTL
=======================

Name: ring_token_arbiter

Overview:
- Per-core ring controller that shares the single circulating ring token among local requesters: DCache, messenger, locker and barrier unit.
- Sits between the core's ring input and its registered ring output stage.
- On a token slot, grants one waiting requester (round-robin), muxes that owner's slot outputs onto the ring, and re-inserts the token when the owner stops driving.
- May chain the token directly to further local waiters, up to MAX_CHAIN grants per capture.

Parameters:
- N_REQ, 4, number of local requesters; index 0 = DCache.
- MAX_CHAIN, 2, maximum grants per token capture (1..15).
- INIT_TOKEN, 0, 1 = this core injects the first token after reset.
- TOKEN_TYPE, 1, slot type code for Token.
- NULL_TYPE, 7, slot type code for Null.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- RingIn  in  32  ring data from upstream.
- SlotTypeIn  in  4  upstream slot type.
- SourceIn  in  4  upstream slot source.
- whichCore  in  4  this core's ID.
- wantsToken  in  N_REQ  per-requester token request; held until granted.
- reqDriveRing  in  N_REQ  requester is driving the ring this cycle.
- reqRingOut  in  32*N_REQ  requester slot data; slice i = bits [32i+31:32i].
- reqSlotTypeOut  in  4*N_REQ  requester slot types.
- acquireToken  out  N_REQ  one-hot grant; combinational, valid in the cycle the token (or chained free slot) is at RingIn.
- RingOut  out  32  registered ring data to downstream.
- SlotTypeOut  out  4  registered slot type.
- SourceOut  out  4  registered source.
- tokenHeld  out  1  registered; 1 while in OWNED or RELEASE.

Behaviour:
- Reset (reset=0, async): state IDLE, rrPtr=0, chainCnt=0, owner=0, acquireToken=0, RingOut=0, SlotTypeOut=NULL_TYPE, SourceOut=0, tokenHeld=0.
- Ring stage latency is exactly 1 cycle: RingOut/SlotTypeOut/SourceOut <= next-slot mux.
- Pass-through default: RingIn/SlotTypeIn/SourceIn.
- When a local slot is emitted: SourceOut=whichCore.
- States:
  - INJECT: entered after reset release only when INIT_TOKEN=1. Emits a Token slot in the first cycle with SlotTypeIn==NULL_TYPE, then -> IDLE.
  - IDLE: if SlotTypeIn==TOKEN_TYPE and |wantsToken:
    - grant the first set bit at or after rrPtr (wrapping); acquireToken[g]=1 that cycle.
    - the granted requester's reqRingOut/reqSlotTypeOut replace the token; if reqDriveRing[g]=0, emit Null.
    - owner<=g, rrPtr<=g+1 mod N_REQ, chainCnt<=1, -> OWNED.
    - Token with no requests: pass through.
  - OWNED: mux owner's outputs while reqDriveRing[owner]=1. First cycle with reqDriveRing[owner]=0:
    - if chainCnt<MAX_CHAIN, another requester wants (round-robin from rrPtr, may be the same owner), and SlotTypeIn==NULL_TYPE: grant as in IDLE using the free slot, chainCnt+1, stay OWNED.
    - else -> RELEASE.
  - RELEASE: emit Token slot (data 0, SourceOut=whichCore) in the first cycle with SlotTypeIn==NULL_TYPE, then -> IDLE. Non-Null incoming slots pass through while waiting.
- Never more than one bit of acquireToken set.
- Grants are never issued in RELEASE or INJECT.
- A second Token arriving while in OWNED/RELEASE is a protocol error: pass it through and set a sticky tokenDup flag (simulation assertion; no port).
- wantsToken dropping without a grant is legal; the requester is simply skipped.
- Reset mid-burst: the token is lost; the INIT_TOKEN core re-injects it.

Decomposition:
- Shared package: slot type constants (Token=1, Address=2, WriteData=3, ReadData=4, Null=7) and the state encoding.
- One sub-module: rr_pick, a combinational round-robin priority picker taking request vector and pointer, returning one-hot grant plus a valid bit. Reused by the chain path.

Test Plan:
- INIT_TOKEN=1, no requests: after reset release and Null input, SlotTypeOut=1 one cycle later; subsequent Token at RingIn reappears at RingOut next cycle unchanged.
- wantsToken=4'b0001, Token arrives: acquireToken=0001 same cycle. DCache drives Address {4'b0001,addr}, then 8 WriteData, then stops. RingOut shows those 9 slots in order, then Token on the next Null input slot; tokenHeld low afterward.
- wantsToken=4'b1010, rrPtr=0, MAX_CHAIN=2: grants go to index 1, then chained to index 3 on the first Null slot after owner 1 releases, then Token emitted; next capture starts at index 0.
- MAX_CHAIN=1 with two requesters: only one grant per capture; the Token must circulate before the second grant.
- Owner releases while SlotTypeIn=ReadData: ReadData passes through unchanged; Token is emitted in the next Null slot.
- Assert reset in OWNED mid-burst: all outputs return to reset values asynchronously, with no acquireToken glitch; INIT_TOKEN core re-injects the token after release.

Source files
------------

// File: rtl/ring_token_arbiter_pkg.sv
// ring_token_arbiter_pkg: slot type codes and controller state encoding
package ring_token_arbiter_pkg;
  localparam logic [3:0] SLOT_TOKEN   = 4'd1;
  localparam logic [3:0] SLOT_ADDRESS = 4'd2;
  localparam logic [3:0] SLOT_WDATA   = 4'd3;
  localparam logic [3:0] SLOT_RDATA   = 4'd4;
  localparam logic [3:0] SLOT_NULL    = 4'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_INJECT, ST_OWNED, ST_RELEASE} state_e;
endpackage

// File: rtl/ring_token_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after the pointer
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] j;
  // scan offsets downward so the smallest offset from the pointer is written last and wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter: shares the circulating ring token among local requesters
module ring_token_arbiter
  import ring_token_arbiter_pkg::*;
#(
  parameter int         N_REQ      = 4,
  parameter int         MAX_CHAIN  = 2,
  parameter int         INIT_TOKEN = 0,
  parameter logic [3:0] TOKEN_TYPE = SLOT_TOKEN,
  parameter logic [3:0] NULL_TYPE  = SLOT_NULL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       RingIn,
  input  logic [3:0]        SlotTypeIn,
  input  logic [3:0]        SourceIn,
  input  logic [3:0]        whichCore,
  input  logic [N_REQ-1:0]  wantsToken,
  input  logic [N_REQ-1:0]  reqDriveRing,
  input  logic [32*N_REQ-1:0] reqRingOut,
  input  logic [4*N_REQ-1:0]  reqSlotTypeOut,
  output logic [N_REQ-1:0]  acquireToken,
  output logic [31:0]       RingOut,
  output logic [3:0]        SlotTypeOut,
  output logic [3:0]        SourceOut,
  output logic              tokenHeld
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // the injecting core starts in INJECT so the first Null slot after reset carries the token
  localparam state_e RESET_STATE = (INIT_TOKEN != 0) ? ST_INJECT : ST_IDLE;
  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [3:0]    chain_q, chain_d;
  logic [31:0]   ring_q, ring_d;
  logic [3:0]    type_q, type_d, src_q, src_d;
  logic          held_q, dup_q, dup, grant;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_vld, is_tok, is_null, own_drive, pick_drive;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i   (wantsToken),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );
  assign is_tok     = SlotTypeIn == TOKEN_TYPE;
  assign is_null    = SlotTypeIn == NULL_TYPE;
  assign own_drive  = reqDriveRing[owner_q];
  assign pick_drive = reqDriveRing[pick_idx];
  // next-slot mux, grant decision and state transitions; grants are masked during reset
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_ptr_d = rr_ptr_q;
    chain_d = chain_q;
    ring_d = RingIn;
    type_d = SlotTypeIn;
    src_d = SourceIn;
    grant = 1'b0;
    dup = 1'b0;
    case (state_q)
      ST_INJECT: if (is_null) begin
        ring_d = '0;
        type_d = TOKEN_TYPE;
        src_d = whichCore;
        state_d = ST_IDLE;
      end
      ST_IDLE: grant = reset && is_tok && pick_vld;
      ST_OWNED: begin
        dup = is_tok;
        if (own_drive) begin
          if (!is_tok) begin
            ring_d = reqRingOut[32*int'(owner_q) +: 32];
            type_d = reqSlotTypeOut[4*int'(owner_q) +: 4];
            src_d = whichCore;
          end
        end else if (chain_q < 4'(MAX_CHAIN) && pick_vld && is_null) grant = reset;
        else state_d = ST_RELEASE;
      end
      default: begin
        dup = is_tok;
        if (is_null) begin
          ring_d = '0;
          type_d = TOKEN_TYPE;
          src_d = whichCore;
          state_d = ST_IDLE;
        end
      end
    endcase
    if (grant) begin
      owner_d = pick_idx;
      rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      chain_d = (state_q == ST_IDLE) ? 4'd1 : chain_q + 4'd1;
      state_d = ST_OWNED;
      ring_d = pick_drive ? reqRingOut[32*int'(pick_idx) +: 32] : '0;
      type_d = pick_drive ? reqSlotTypeOut[4*int'(pick_idx) +: 4] : NULL_TYPE;
      src_d = whichCore;
    end
  end
  assign acquireToken = grant ? pick_gnt : '0;
  // controller state, registered ring stage and sticky duplicate-token flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      owner_q <= '0;
      rr_ptr_q <= '0;
      chain_q <= '0;
      ring_q <= '0;
      type_q <= NULL_TYPE;
      src_q <= '0;
      held_q <= 1'b0;
      dup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      chain_q <= chain_d;
      ring_q <= ring_d;
      type_q <= type_d;
      src_q <= src_d;
      held_q <= (state_d == ST_OWNED) || (state_d == ST_RELEASE);
      dup_q <= dup_q | dup;
    end
  end
  assign RingOut = ring_q;
  assign SlotTypeOut = type_q;
  assign SourceOut = src_q;
  assign tokenHeld = held_q;
  assert property (@(posedge clock) disable iff (!reset) $onehot0(acquireToken));
  assert property (@(posedge clock) disable iff (!reset) !dup_q);
endmodule
